// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetch FIFO between the memory port and decode
module instr_prefetch_queue #(
    parameter int                 DEPTH        = 4,
    parameter logic [31:0]        BOOT_ADDR    = 32'h0000_0000,
    parameter int                 EXC_LEN      = 4,
    parameter logic [EXC_LEN-1:0] EXC_MISALIGN = EXC_LEN'(1)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       valid_out,
    output logic [31:0]                pc_out,
    output logic [31:0]                instr_out,
    output logic [EXC_LEN-1:0]         exc_out,
    input  logic                       consume_in,
    input  logic                       redirect_in,
    input  logic [31:0]                redirect_pc_in,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic [31:0]                mem_addr_out,
    output logic                       mem_req_out,
    input  logic                       mem_ok_in,
    input  logic [31:0]                mem_data_in,
    input  logic [EXC_LEN-1:0]         mem_exc_in
);

    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]        pc_mem    [DEPTH];
    logic [31:0]        instr_mem [DEPTH];
    logic [EXC_LEN-1:0] exc_mem   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          halted;
    logic [31:0]   fetch_pc;
    logic          push;
    logic          pop;
    logic          misalign;

    // Only one request can be outstanding: it stays asserted until mem_ok_in completes it.
    assign mem_req_out  = !halted && !redirect_in && (count < CW'(DEPTH));
    assign push         = mem_req_out && mem_ok_in;
    assign valid_out    = (count != '0);
    assign pop          = valid_out && consume_in;
    assign misalign     = (redirect_pc_in[1:0] != 2'b00);
    assign mem_addr_out = fetch_pc;
    assign count_out    = count;

    assign pc_out    = pc_mem[rd_ptr];
    assign instr_out = instr_mem[rd_ptr];
    assign exc_out   = exc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            halted   <= 1'b0;
            fetch_pc <= BOOT_ADDR;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                exc_mem[i]   <= '0;
            end
        end else if (redirect_in) begin
            // Redirect overrides any same-cycle push or pop.
            rd_ptr   <= '0;
            fetch_pc <= redirect_pc_in;
            if (misalign) begin
                pc_mem[0]    <= redirect_pc_in;
                instr_mem[0] <= NOP;
                exc_mem[0]   <= EXC_MISALIGN;
                wr_ptr       <= AW'(1);
                count        <= CW'(1);
                halted       <= 1'b1;
            end else begin
                wr_ptr <= '0;
                count  <= '0;
                halted <= 1'b0;
            end
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= mem_data_in;
                exc_mem[wr_ptr]   <= mem_exc_in;
                wr_ptr            <= wr_ptr + AW'(1);
                fetch_pc          <= fetch_pc + 32'd4;
                if (mem_exc_in != '0) begin
                    halted <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed vector bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [3:0]  exc_out;
    logic        consume_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [2:0]  count_out;
    logic [31:0] mem_addr_out;
    logic        mem_req_out;
    logic        mem_ok_in;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_exc_in;

    int checks = 0;
    int errors = 0;

    instr_prefetch_queue #(
        .DEPTH(4),
        .BOOT_ADDR(32'h0000_0000),
        .EXC_LEN(4),
        .EXC_MISALIGN(4'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_out(valid_out),
        .pc_out(pc_out),
        .instr_out(instr_out),
        .exc_out(exc_out),
        .consume_in(consume_in),
        .redirect_in(redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .count_out(count_out),
        .mem_addr_out(mem_addr_out),
        .mem_req_out(mem_req_out),
        .mem_ok_in(mem_ok_in),
        .mem_data_in(mem_data_in),
        .mem_exc_in(mem_exc_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        consume;
        logic        redirect;
        logic [31:0] rpc;
        logic        ok;
        logic [31:0] data;
        logic [3:0]  exc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [3:0]  e_exc;
        logic [2:0]  e_count;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic c, input logic r, input logic [31:0] rpc,
                                input logic ok, input logic [31:0] d, input logic [3:0] x,
                                input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                                input logic [3:0] ex, input logic [2:0] ec, input logic erq,
                                input logic [31:0] ea);
        vec_t v;
        v.consume = c;   v.redirect = r;  v.rpc = rpc;
        v.ok = ok;       v.data = d;      v.exc = x;
        v.e_valid = ev;  v.e_pc = epc;    v.e_instr = ei;
        v.e_exc = ex;    v.e_count = ec;  v.e_req = erq;
        v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // cons red rpc          ok data          exc  valid pc           instr         exc cnt req addr
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h1000_0000, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h1000_0004, 0, 1, 32'h0,        32'h1000_0000, 0, 1, 1, 32'h4));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h1000_0008, 0, 1, 32'h0,        32'h1000_0000, 0, 2, 1, 32'h8));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h1000_000C, 0, 1, 32'h0,        32'h1000_0000, 0, 3, 1, 32'hC));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 1, 32'h0,        32'h1000_0000, 0, 4, 0, 32'h10));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 1, 32'h0,        32'h1000_0000, 0, 4, 0, 32'h10));
        vq.push_back(mk(1, 0, 32'h0,        0, 32'h0,         0, 1, 32'h0,        32'h1000_0000, 0, 4, 0, 32'h10));
        vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h4,        32'h1000_0004, 0, 3, 1, 32'h10));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h1000_0010, 0, 1, 32'h4,        32'h1000_0004, 0, 3, 1, 32'h10));
        vq.push_back(mk(0, 1, 32'h100,      1, 32'hDEAD_BEEF, 0, 1, 32'h4,        32'h1000_0004, 0, 4, 0, 32'h14));
        vq.push_back(mk(1, 0, 32'h0,        0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h100));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h2000_0100, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h100));
        vq.push_back(mk(1, 0, 32'h0,        1, 32'h2000_0104, 0, 1, 32'h100,      32'h2000_0100, 0, 1, 1, 32'h104));
        vq.push_back(mk(1, 0, 32'h0,        0, 32'h0,         0, 1, 32'h104,      32'h2000_0104, 0, 1, 1, 32'h108));
        vq.push_back(mk(0, 1, 32'h200,      1, 32'h0000_0BAD, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h108));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h3000_0200, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h200));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h3000_0204, 5, 1, 32'h200,      32'h3000_0200, 0, 1, 1, 32'h204));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 1, 32'h200,      32'h3000_0200, 0, 2, 0, 32'h208));
        vq.push_back(mk(1, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 1, 32'h200,      32'h3000_0200, 0, 2, 0, 32'h208));
        vq.push_back(mk(0, 1, 32'h40,       0, 32'h0,         0, 1, 32'h204,      32'h3000_0204, 5, 1, 0, 32'h208));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h5000_0040, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h40));
        vq.push_back(mk(0, 1, 32'h102,      1, 32'hDEAD_BEEF, 0, 1, 32'h40,       32'h5000_0040, 0, 1, 0, 32'h44));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 1, 32'h102,      32'h0000_0013, 1, 1, 0, 32'h102));
        vq.push_back(mk(1, 0, 32'h0,        0, 32'h0,         0, 1, 32'h102,      32'h0000_0013, 1, 1, 0, 32'h102));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h102));
        vq.push_back(mk(0, 1, 32'h300,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h102));
        vq.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h300));
        vq.push_back(mk(0, 0, 32'h0,        1, 32'h4000_FFFC, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'hFFFF_FFFC));
        vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'h4000_FFFC, 0, 1, 1, 32'h0));

        rst = 1'b1;
        consume_in = 1'b0;
        redirect_in = 1'b0;
        redirect_pc_in = '0;
        mem_ok_in = 1'b0;
        mem_data_in = '0;
        mem_exc_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset valid", 32'(valid_out), 32'd0);
        chk("reset count", 32'(count_out), 32'd0);
        chk("reset pc", pc_out, 32'h0);
        chk("reset instr", instr_out, 32'h0);
        chk("reset exc", 32'(exc_out), 32'd0);
        chk("reset req", 32'(mem_req_out), 32'd1);
        chk("reset addr", mem_addr_out, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            consume_in     = vq[i].consume;
            redirect_in    = vq[i].redirect;
            redirect_pc_in = vq[i].rpc;
            mem_ok_in      = vq[i].ok;
            mem_data_in    = vq[i].data;
            mem_exc_in     = vq[i].exc;
            #2;
            chk($sformatf("v%0d valid", i), 32'(valid_out), 32'(vq[i].e_valid));
            chk($sformatf("v%0d count", i), 32'(count_out), 32'(vq[i].e_count));
            chk($sformatf("v%0d req", i), 32'(mem_req_out), 32'(vq[i].e_req));
            chk($sformatf("v%0d addr", i), mem_addr_out, vq[i].e_addr);
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d pc", i), pc_out, vq[i].e_pc);
                chk($sformatf("v%0d instr", i), instr_out, vq[i].e_instr);
                chk($sformatf("v%0d exc", i), 32'(exc_out), 32'(vq[i].e_exc));
            end
            @(posedge clk);
            #1;
        end

        // Reset while a request is pending and its response arrives in the reset cycle.
        consume_in  = 1'b0;
        redirect_in = 1'b0;
        mem_ok_in   = 1'b1;
        mem_data_in = 32'h7777_7777;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ok_in = 1'b0;
        #1;
        chk("rst mid valid", 32'(valid_out), 32'd0);
        chk("rst mid count", 32'(count_out), 32'd0);
        chk("rst mid pc", pc_out, 32'h0);
        chk("rst mid instr", instr_out, 32'h0);
        chk("rst mid req", 32'(mem_req_out), 32'd1);
        chk("rst mid addr", mem_addr_out, 32'h0);
        @(posedge clk);
        #2;
        chk("rst drop count", 32'(count_out), 32'd0);
        chk("rst drop addr", mem_addr_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Parametrised successor to the single-entry instruction fetch stage. It prefetches sequential 32-bit instructions into a DEPTH-entry FIFO. Each entry carries its PC, instruction word and exception code. Decode drains the FIFO with a valid/consume handshake. A redirect from execute flushes the FIFO and restarts fetch at a new PC. The block sits between the shared memory port and decode.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
BOOT_ADDR, 32'h0000_0000, fetch PC after reset
EXC_LEN, 4, exception code width; 0 = no exception
EXC_MISALIGN, 4'd1, code pushed for a redirect PC with bits [1:0] != 0

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high; clock clk
valid_out  out  1  head entry present
pc_out  out  32  head entry PC
instr_out  out  32  head entry instruction
exc_out  out  EXC_LEN  head entry exception code
consume_in  in  1  decode takes the head entry this cycle (pop when valid_out)
redirect_in  in  1  flush FIFO and restart fetch
redirect_pc_in  in  32  restart PC
count_out  out  $clog2(DEPTH)+1  current occupancy
mem_addr_out  out  32  fetch address (= fetch_pc)
mem_req_out  out  1  read request, word width
mem_ok_in  in  1  response valid; completes the request
mem_data_in  in  32  response data
mem_exc_in  in  EXC_LEN  response exception code

Behaviour:
- Reset values: fetch_pc = BOOT_ADDR; count = 0; halted = 0; valid_out = 0; pc_out, instr_out and exc_out = 0; mem_req_out high in the first cycle after rst deasserts.
- Issue rule: mem_req_out = !halted && !redirect_in && (count < DEPTH).
  - Combinational; only one request is ever outstanding.
  - The request is held until mem_ok_in.
  - mem_ok_in while mem_req_out is low is ignored.
- Push: on mem_req_out && mem_ok_in, write {fetch_pc, mem_data_in, mem_exc_in} at the tail.
  - Then fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
  - If mem_exc_in != 0, set halted <= 1; no further requests until a redirect.
- Latency: response in cycle T with the FIFO empty → valid_out = 1 in cycle T+1.
  - Back-to-back single-cycle responses sustain one instruction per cycle.
- Pop: on valid_out && consume_in, the head advances next cycle. consume_in while valid_out = 0 is ignored.
- Head outputs come straight from storage at the read pointer. Values are don't-care when valid_out = 0, but must be stable while valid_out = 1 and there is no pop.
- Push and pop in the same cycle: count is unchanged. This is legal at count = DEPTH because the issue rule blocks a push at full.
- Full: count = DEPTH → mem_req_out = 0; it resumes the cycle after a pop.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count_out = count.
- Redirect (redirect_in = 1) has priority over push and pop in the same cycle:
  - Next cycle: count = 0, pointers = 0, halted = 0, fetch_pc = redirect_pc_in.
  - mem_req_out is forced low during the redirect cycle, and any mem_ok_in in that cycle is discarded.
  - The first request to the new PC is issued in cycle R+1.
- Misaligned redirect (redirect_pc_in[1:0] != 0):
  - Next cycle the FIFO holds exactly one entry {redirect_pc_in, 32'h0000_0013 (NOP), EXC_MISALIGN}, and halted = 1.
  - No memory request is made.
- Back-to-back redirects: the last one wins; each flushes.
- rst asserted mid-request: all state returns to reset values and any in-flight response is dropped.

Test Plan:
- Reset, BOOT_ADDR=0, DEPTH=4, memory answers in 1 cycle, consume_in=0 → 4 pushes with PCs 0,4,8,C; count_out=4; mem_req_out=0; head pc_out=0.
- Same setup, consume_in=1 throughout → valid_out stays high from cycle 2 with PCs 0,4,8,... one per cycle; count_out stays ≤1.
- Redirect to 0x100 while a request to 0x8 is pending and mem_ok_in coincides → FIFO empty next cycle; the response is dropped; next mem_addr_out=0x100; first valid pc_out=0x100.
- mem_exc_in=4'h5 on the fetch of 0x8 → entry 0x8 carries exc_out=5; no request for 0xC; after redirect to 0x40, fetch resumes at 0x40.
- Redirect to 0x102 → single entry with pc_out=0x102, exc_out=EXC_MISALIGN, instr_out=0x00000013; mem_req_out stays low until the next redirect.
- Full FIFO with simultaneous pop and mem_ok_in held off → count goes 4→3; mem_req_out rises next cycle; fetch_pc wraps 0xFFFF_FFFC→0x0 when started there.
